// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : data-memory responder with req/ack handshake, programmable
// wait states and misaligned/out-of-range error reporting.  Rev 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int ADDR_W  = 5,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        pcrst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_ack;
  logic                r_err;
  logic [31:0]         r_mem [DEPTH];

  logic                w_bad;
  logic [ADDR_W-1:0]   w_idx;

  // Decoded from the latched request so mid-transaction input changes are inert
  assign w_bad = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_W+2] != '0);
  assign w_idx = r_addr[ADDR_W+1:2];

  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= CNT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_ack   <= 1'b1;
            r_state <= S_RESP;
            if (w_bad) begin
              r_rdata <= 32'd0;
              r_err   <= 1'b1;
            end else if (r_we) begin
              r_mem[w_idx] <= r_wdata;
              r_err        <= 1'b0;
            end else begin
              r_rdata <= r_mem[w_idx];
              r_err   <= 1'b0;
            end
          end
        end
        S_RESP: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign err   = r_err;
  assign busy  = (r_state != S_IDLE);

endmodule

`default_nettype wire
